// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: state encoding,
// default word width and small width helpers used by the feeder and its FIFO.
package uart_pkg;

    // Default word width, matching the UART_Tx frame size.
    localparam int DEFAULT_DATA_W = 32;

    // Feeder FSM state encoding.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_CHECK     = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        SEND      = ST_SEND,
        WAIT_DONE = ST_WAIT_DONE,
        CHECK     = ST_CHECK
    } feeder_state_e;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Retry counter width; a zero retry budget still needs one bit of storage.
    function automatic int retry_width(input int max_retry);
        return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO. The head word is always visible on RdData;
// RdEn consumes it. Writes while full and reads while empty are ignored,
// so the occupancy counter can never wrap.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = count_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WrEn,
    input  logic [DATA_W-1:0] WrData,
    input  logic              RdEn,
    output logic [DATA_W-1:0] RdData,
    output logic              Full,
    output logic              Empty,
    output logic [CNT_W-1:0]  Count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_fire;
    logic              rd_fire;

    // Status flags come straight from the registered occupancy count.
    assign Full   = (count_q == CNT_W'(DEPTH));
    assign Empty  = (count_q == '0);
    assign Count  = count_q;
    assign RdData = mem_q[rd_ptr_q];

    // Full/Empty are the pre-edge values, so a pop never frees room for a same-cycle write.
    assign wr_fire = WrEn && !Full;
    assign rd_fire = RdEn && !Empty;

    // Next pointer and occupancy values; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while Empty so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= WrData;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered word source for UART_Tx. Host words queue in a small FIFO; each
// word is presented on DataIn with a one-cycle NewData strobe, the feeder
// waits for a fresh DoneTx rising edge, then checks the receiver parity flag
// and resends the same word up to MAX_RETRY times before dropping it.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int DATA_W    = DEFAULT_DATA_W,
    parameter  int DEPTH     = 4,
    parameter  int MAX_RETRY = 3,
    localparam int CNT_W     = count_width(DEPTH)
) (
    input  logic              CLK_Baudin,
    input  logic              RstTx,
    input  logic              WrEn,
    input  logic [DATA_W-1:0] WrData,
    output logic              Full,
    output logic              Empty,
    output logic [CNT_W-1:0]  Count,
    output logic              WrOvf,
    output logic [DATA_W-1:0] DataIn,
    output logic              NewData,
    input  logic              DoneTx,
    input  logic              Flag_in,
    output logic              Busy,
    output logic              DropPulse
);

    localparam int                 RETRY_W     = retry_width(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    feeder_state_e     state_q, state_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic              new_data_q, new_data_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic              wr_ovf_q, wr_ovf_d;
    logic              done_prev_q;
    logic              done_rise;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (CLK_Baudin),
        .rst    (RstTx),
        .WrEn   (WrEn),
        .WrData (WrData),
        .RdEn   (fifo_rd_en),
        .RdData (fifo_head),
        .Full   (fifo_full),
        .Empty  (fifo_empty),
        .Count  (Count)
    );

    // Only IDLE consumes from the queue; the head word is latched into DataIn on that edge.
    assign fifo_rd_en = (state_q == IDLE) && !fifo_empty;

    // A frame completes only on a fresh 0->1 transition, never on a level left high earlier.
    assign done_rise = DoneTx && !done_prev_q;

    // Next-state, retry bookkeeping and the registered output values.
    always_comb begin
        state_d   = state_q;
        data_in_d = data_in_q;
        retry_d   = retry_q;
        drop_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    data_in_d = fifo_head;
                    retry_d   = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!Flag_in) begin
                    state_d = IDLE;
                end else if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = SEND;
                end else begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        new_data_d = (state_d == SEND);
        busy_d     = (state_d != IDLE);
        wr_ovf_d   = WrEn && fifo_full;
    end

    // Single state register with all outputs registered alongside it.
    always_ff @(posedge CLK_Baudin or posedge RstTx) begin
        if (RstTx) begin
            state_q     <= IDLE;
            data_in_q   <= '0;
            retry_q     <= '0;
            new_data_q  <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
            wr_ovf_q    <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_in_q   <= data_in_d;
            retry_q     <= retry_d;
            new_data_q  <= new_data_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
            wr_ovf_q    <= wr_ovf_d;
            done_prev_q <= DoneTx;
        end
    end

    assign Full      = fifo_full;
    assign Empty     = fifo_empty;
    assign WrOvf     = wr_ovf_q;
    assign DataIn    = data_in_q;
    assign NewData   = new_data_q;
    assign Busy      = busy_q;
    assign DropPulse = drop_q;

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Buffered word source placed directly upstream of UART_Tx. It accepts 32-bit words from the host side into a small FIFO and presents them to the transmitter one at a time on DataIn/NewData. It waits for each frame's DoneTx, samples the receiver's parity-error flag, and re-issues the same word up to MAX_RETRY times before dropping it.

## Interface
Parameters:
- DATA_W, 32, word width; must equal UART_Tx `size`.
- DEPTH, 4, FIFO depth; power of two, ≥2.
- MAX_RETRY, 3, resends allowed after the first attempt; 0 disables retry.

Ports:
- CLK_Baudin  in  1  baud clock shared with UART_Tx/UART_Rx.
- RstTx  in  1  reset, asynchronous, active-high. Same net as the UART_Tx reset.
- WrEn  in  1  host write strobe.
- WrData  in  DATA_W  host word.
- Full  out  1  FIFO full; a write while high is discarded.
- Empty  out  1  FIFO empty.
- Count  out  $clog2(DEPTH)+1  FIFO occupancy.
- WrOvf  out  1  one-cycle pulse on a discarded write.
- DataIn  out  DATA_W  word to UART_Tx; held stable from SEND through CHECK.
- NewData  out  1  one-cycle start strobe to UART_Tx.
- DoneTx  in  1  frame-complete from UART_Tx.
- Flag_in  in  1  parity-error flag from UART_Rx (Flag_Rx).
- Busy  out  1  high in any state other than IDLE.
- DropPulse  out  1  one-cycle pulse when a word is abandoned after MAX_RETRY resends.

## Operation
- FSM states: IDLE, SEND, WAIT_DONE, CHECK.
- IDLE
  - If !Empty: DataIn <= FIFO head, pop, clear retry count, go to SEND.
  - Otherwise stay in IDLE.
- SEND: NewData = 1 for exactly this cycle; go to WAIT_DONE.
- WAIT_DONE: wait for a DoneTx rising edge (DoneTx=1 and registered previous value=0), then go to CHECK. A DoneTx level left high from an earlier frame does not count.
- CHECK: sample Flag_in.
  - Flag_in = 0: success; go to IDLE.
  - Flag_in = 1 and retry < MAX_RETRY: retry++; go to SEND with the same DataIn.
  - Flag_in = 1 and retry = MAX_RETRY: DropPulse = 1; go to IDLE.
- FIFO write rules:
  - A write is accepted iff WrEn && !Full, with Full evaluated before the edge.
  - A write and an IDLE pop in the same cycle when Full: the write is discarded and WrOvf pulses.
  - A write and a pop on a non-full FIFO: Count is unchanged.
- Pointers wrap modulo DEPTH. Count saturates at neither end because the rules above make over/underflow unreachable.
- Reset (asynchronous):
  - State = IDLE; pointers, Count and retry = 0; Empty = 1.
  - Full, WrOvf, NewData, Busy, DropPulse = 0; DataIn = 0.
  - A reset mid-frame abandons the word in flight and the FIFO contents.

## Timing
- All state changes occur on the rising edge of CLK_Baudin. Outputs are registered or Moore-decoded from state; there is no combinational path from input to output.
- Write on edge k into an empty FIFO in IDLE:
  - Empty falls after edge k.
  - The pop happens at edge k+1.
  - NewData is high in the cycle between edges k+1 and k+2.
- Retry: NewData re-asserts one cycle after CHECK. The minimum gap between a DoneTx edge and the next NewData is 2 cycles.
- Back-to-back words: the IDLE cycle between CHECK and the next SEND is mandatory, giving 1 idle cycle minimum.
- WrOvf and DropPulse are high for exactly one cycle.

## Structure
- Shared package uart_pkg:
  - FSM state encoding: 2-bit localparams IDLE=0, SEND=1, WAIT_DONE=2, CHECK=3.
  - Default DATA_W = 32.
- One sub-module, uart_sync_fifo, parameterised by DATA_W and DEPTH.
  - Ports: WrEn, WrData, RdEn, RdData (head, show-ahead), Full, Empty, Count.
- FSM, retry counter and DoneTx edge register live in uart_tx_feeder.

## Test plan
- Single word, clean link:
  - Stimulus: after reset, write 32'hA5A5F0F0; Flag_in = 0 throughout.
  - Required: one NewData pulse 2 cycles after the write; DataIn = A5A5F0F0; Busy drops one cycle after DoneTx rises; DropPulse never asserts.
- Single retry:
  - Stimulus: first frame with Flag_in = 1 at CHECK, second frame with Flag_in = 0.
  - Required: exactly two NewData pulses with identical DataIn; FIFO Count ends at 0.
- Retry exhaustion:
  - Stimulus: Flag_in held at 1, MAX_RETRY = 3.
  - Required: 4 NewData pulses, then DropPulse for 1 cycle, then the next queued word is loaded.
- Overflow:
  - Stimulus: with DoneTx held low, write 6 words 1..6 (DEPTH = 4).
  - Required:
    - Word 1 is popped into DataIn; words 2..5 fill the FIFO, Full = 1.
    - Word 6 produces WrOvf.
    - Drained order is 1,2,3,4,5.
- Reset mid-frame:
  - Stimulus: assert RstTx during WAIT_DONE with 2 words queued.
  - Required: all outputs return to their reset values asynchronously; after release no NewData occurs until a new write.
